// File: rtl/uart_rx_fe_pkg.sv
// Shared definitions for the uart_rx_fe receiver: parity modes, FSM states and
// an elaboration-time clog2 for sizing counters.
package uart_rx_fe_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fe_bit_sampler.sv
// Line front end: 2-flop synchroniser, start-edge detect, baud counter and
// 3-sample majority vote producing one decision strobe per bit.
module uart_rx_fe_bit_sampler
  import uart_rx_fe_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 5207
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic idle,
  output logic start_edge,
  output logic bit_strobe,
  output logic bit_val,
  output logic rx_sync
);

  localparam int unsigned CW = clog2(BAUD_CNT_MAX);
  localparam int unsigned H  = BAUD_CNT_MAX / 2;

  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic [CW-1:0] cnt;
  logic          samp_a;
  logic          samp_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (start_edge) begin
        cnt <= '0;
      end else if (!idle) begin
        cnt <= (cnt == CW'(BAUD_CNT_MAX - 1)) ? '0 : cnt + CW'(1);
      end
      if (!idle && cnt == CW'(H - 1)) samp_a <= sync2;
      if (!idle && cnt == CW'(H))     samp_b <= sync2;
    end
  end

  // The third vote is the live synced value at the decision count.
  assign start_edge = idle && sync_prev && !sync2;
  assign bit_strobe = !idle && (cnt == CW'(H + 1));
  assign bit_val    = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
  assign rx_sync    = sync2;

endmodule

// File: rtl/uart_rx_fe.sv
// UART receiver: frame FSM, parity/stop/break checks and a one-entry holding
// register with valid/ready handshake and overrun pulse.
module uart_rx_fe
  import uart_rx_fe_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 5207,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned BCW = clog2(DATA_BITS);

  logic                 start_edge;
  logic                 bit_strobe;
  logic                 bit_val;
  logic                 rx_sync;
  rx_state_t            state;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_err_q;
  logic                 ferr_acc;
  logic                 stop0_zero;
  logic                 stop_cnt;
  logic                 done;
  logic                 frame_ferr;
  logic                 frame_brk;

  uart_rx_fe_bit_sampler #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .idle       (state == ST_IDLE),
    .start_edge (start_edge),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .rx_sync    (rx_sync)
  );

  always_comb begin
    done       = (state == ST_STOP) && bit_strobe && (stop_cnt == 1'(STOP_BITS - 1));
    frame_ferr = ferr_acc | !bit_val;
    frame_brk  = (shreg == '0) && ((PARITY == PARITY_NONE) || !par_bit) &&
                 ((stop_cnt == 1'b0) ? !bit_val : stop0_zero);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_err_q  <= 1'b0;
      ferr_acc   <= 1'b0;
      stop0_zero <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_edge) begin
          state      <= ST_START;
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          par_bit    <= 1'b0;
          par_err_q  <= 1'b0;
          ferr_acc   <= 1'b0;
          stop0_zero <= 1'b0;
        end
        ST_START: if (bit_strobe) state <= bit_val ? ST_IDLE : ST_DATA;
        ST_DATA: if (bit_strobe) begin
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        ST_PARITY: if (bit_strobe) begin
          par_bit   <= bit_val;
          par_err_q <= (PARITY == PARITY_ODD) ? !(^shreg ^ bit_val) : (^shreg ^ bit_val);
          state     <= ST_STOP;
        end
        ST_STOP: if (bit_strobe) begin
          if (stop_cnt == 1'b0) stop0_zero <= !bit_val;
          ferr_acc <= frame_ferr;
          // Leaving on the strobe lets a new start edge land in the last half stop bit.
          if (done) state <= frame_brk ? ST_BRK_WAIT : ST_IDLE;
          else      stop_cnt <= stop_cnt + 1'b1;
        end
        ST_BRK_WAIT: if (rx_sync) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          valid      <= 1'b1;
          data       <= frame_brk ? '0 : shreg;
          parity_err <= frame_brk ? 1'b0 : par_err_q;
          frame_err  <= frame_brk | frame_ferr;
          break_det  <= frame_brk;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fe.sv
// Directed bench for uart_rx_fe: three instances (8N1, 7E1, 8N2) at 16 clocks/bit.
module tb_uart_rx_fe;

  localparam int unsigned BAUD = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic rxl [3];
  logic rdy [3];

  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic vld0, vld1, vld2, pe0, pe1, pe2, fe0, fe1, fe2, bd0, bd1, bd2, ov0, ov1, ov2;

  logic       vld [3];
  logic       ov  [3];
  logic [8:0] dat [3];
  logic [2:0] fl  [3];

  int         cyc = 0;
  int         rise_cnt [3] = '{0, 0, 0};
  int         rise_cyc [3] = '{0, 0, 0};
  int         acc_cnt  [3] = '{0, 0, 0};
  int         ovr_cnt  [3] = '{0, 0, 0};
  int         ovr_cyc  [3] = '{0, 0, 0};
  logic [8:0] acc_dat  [3] = '{9'h0, 9'h0, 9'h0};
  logic [2:0] acc_fl   [3] = '{3'h0, 3'h0, 3'h0};
  logic       vprev    [3] = '{1'b0, 1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  uart_rx_fe #(.BAUD_CNT_MAX(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .rx(rxl[0]), .ready(rdy[0]), .data(data0), .valid(vld0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .overrun(ov0));
  uart_rx_fe #(.BAUD_CNT_MAX(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx(rxl[1]), .ready(rdy[1]), .data(data1), .valid(vld1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .overrun(ov1));
  uart_rx_fe #(.BAUD_CNT_MAX(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .rx(rxl[2]), .ready(rdy[2]), .data(data2), .valid(vld2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .overrun(ov2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    vld = '{vld0, vld1, vld2};
    ov  = '{ov0, ov1, ov2};
    dat = '{{1'b0, data0}, {2'b0, data1}, {1'b0, data2}};
    fl  = '{{pe0, fe0, bd0}, {pe1, fe1, bd1}, {pe2, fe2, bd2}};
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !vprev[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        rise_cyc[i] <= cyc;
      end
      if (vld[i] && rdy[i]) begin
        acc_cnt[i] <= acc_cnt[i] + 1;
        acc_dat[i] <= dat[i];
        acc_fl[i]  <= fl[i];
      end
      if (ov[i]) begin
        ovr_cnt[i] <= ovr_cnt[i] + 1;
        ovr_cyc[i] <= cyc;
      end
      vprev[i] <= vld[i];
    end
  end

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // bits[0] is the start bit; the line is left idle high afterwards.
  task automatic send_frame(input int i, input logic [15:0] bits, input int n, output int start_c);
    @(posedge clk); #1;
    start_c = cyc;
    for (int k = 0; k < n; k++) begin
      rxl[i] = bits[k];
      repeat (BAUD) @(posedge clk);
      #1;
    end
    rxl[i] = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin rxl[i] = 1'b1; rdy[i] = 1'b1; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vld[i], ov[i], fl[i], dat[i]} !== 14'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 0", i, {vld[i], ov[i], fl[i], dat[i]});
      end
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_8n1;
    int s, r0, a0;
    r0 = rise_cnt[0]; a0 = acc_cnt[0];
    send_frame(0, f8n1(8'hA5), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (rise_cnt[0] - r0 !== 1) begin errors++; $display("FAIL 8n1_pulses: got %0d expected 1", rise_cnt[0] - r0); end
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL 8n1_accepts: got %0d expected 1", acc_cnt[0] - a0); end
    checks++; if (acc_dat[0] !== 9'h0A5) begin errors++; $display("FAIL 8n1_data: got %h expected 0a5", acc_dat[0]); end
    checks++; if (acc_fl[0] !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b expected 000", acc_fl[0]); end
    checks++; if (rise_cyc[0] - s !== 157) begin errors++; $display("FAIL 8n1_latency: got %0d expected 157", rise_cyc[0] - s); end
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL 8n1_valid_drop: got %b expected 0", vld[0]); end
  endtask

  task automatic test_parity;
    int s;
    send_frame(1, {5'b0, 1'b1, 1'b1, 7'h03, 1'b0}, 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[1] !== 9'h003) begin errors++; $display("FAIL parity_bad_data: got %h expected 003", acc_dat[1]); end
    checks++; if (acc_fl[1] !== 3'b100) begin errors++; $display("FAIL parity_bad_flags: got %b expected 100", acc_fl[1]); end
    send_frame(1, {5'b0, 1'b1, 1'b0, 7'h03, 1'b0}, 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[1] !== 9'h003) begin errors++; $display("FAIL parity_ok_data: got %h expected 003", acc_dat[1]); end
    checks++; if (acc_fl[1] !== 3'b000) begin errors++; $display("FAIL parity_ok_flags: got %b expected 000", acc_fl[1]); end
    checks++; if (rise_cyc[1] - s !== 157) begin errors++; $display("FAIL parity_latency: got %0d expected 157", rise_cyc[1] - s); end
  endtask

  task automatic test_false_start;
    int s, r0;
    r0 = rise_cnt[0];
    @(posedge clk); #1;
    rxl[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxl[0] = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++; if (rise_cnt[0] - r0 !== 0) begin errors++; $display("FAIL false_start_pulses: got %0d expected 0", rise_cnt[0] - r0); end
    send_frame(0, f8n1(8'h3C), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[0] !== 9'h03C) begin errors++; $display("FAIL after_false_data: got %h expected 03c", acc_dat[0]); end
    checks++; if (acc_fl[0] !== 3'b000) begin errors++; $display("FAIL after_false_flags: got %b expected 000", acc_fl[0]); end
    checks++; if (rise_cyc[0] - s !== 157) begin errors++; $display("FAIL after_false_latency: got %0d expected 157", rise_cyc[0] - s); end
  endtask

  task automatic test_two_stop;
    int s;
    send_frame(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[2] !== 9'h055) begin errors++; $display("FAIL stop2_data: got %h expected 055", acc_dat[2]); end
    checks++; if (acc_fl[2] !== 3'b010) begin errors++; $display("FAIL stop2_flags: got %b expected 010", acc_fl[2]); end
    checks++; if (rise_cyc[2] - s !== 173) begin errors++; $display("FAIL stop2_latency: got %0d expected 173", rise_cyc[2] - s); end
  endtask

  task automatic test_break;
    int s, r0;
    r0 = rise_cnt[0];
    @(posedge clk); #1;
    rxl[0] = 1'b0;
    repeat (30 * BAUD) @(posedge clk); #1;
    checks++; if (rise_cnt[0] - r0 !== 1) begin errors++; $display("FAIL break_pulses: got %0d expected 1", rise_cnt[0] - r0); end
    checks++; if (acc_dat[0] !== 9'h000) begin errors++; $display("FAIL break_data: got %h expected 000", acc_dat[0]); end
    checks++; if (acc_fl[0] !== 3'b011) begin errors++; $display("FAIL break_flags: got %b expected 011", acc_fl[0]); end
    rxl[0] = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(0, f8n1(8'h81), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[0] !== 9'h081) begin errors++; $display("FAIL after_break_data: got %h expected 081", acc_dat[0]); end
    checks++; if (acc_fl[0] !== 3'b000) begin errors++; $display("FAIL after_break_flags: got %b expected 000", acc_fl[0]); end
  endtask

  task automatic test_overrun;
    int s, a0, o0;
    rdy[0] = 1'b0;
    a0 = acc_cnt[0]; o0 = ovr_cnt[0];
    send_frame(0, f8n1(8'h11), 10, s);
    send_frame(0, f8n1(8'h22), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", vld[0]); end
    checks++; if (dat[0] !== 9'h011) begin errors++; $display("FAIL ovr_data_held: got %h expected 011", dat[0]); end
    checks++; if (ovr_cnt[0] - o0 !== 1) begin errors++; $display("FAIL ovr_pulse_len: got %0d expected 1", ovr_cnt[0] - o0); end
    checks++; if (ovr_cyc[0] - s !== 157) begin errors++; $display("FAIL ovr_pulse_time: got %0d expected 157", ovr_cyc[0] - s); end
    checks++; if (acc_cnt[0] - a0 !== 0) begin errors++; $display("FAIL ovr_no_accept: got %0d expected 0", acc_cnt[0] - a0); end
    rdy[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", vld[0]); end
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL ovr_accepts: got %0d expected 1", acc_cnt[0] - a0); end
    checks++; if (acc_dat[0] !== 9'h011) begin errors++; $display("FAIL ovr_accept_data: got %h expected 011", acc_dat[0]); end
  endtask

  task automatic test_reset_midframe;
    int s, r0;
    rdy[0] = 1'b0;
    send_frame(0, f8n1(8'h33), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if ({vld[0], dat[0]} !== 10'h233) begin errors++; $display("FAIL pre_reset_hold: got %h expected 233", {vld[0], dat[0]}); end
    r0 = rise_cnt[0];
    rxl[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    rxl[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vld[0], ov[0], fl[0], dat[0]} !== 14'h0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h expected 0", {vld[0], ov[0], fl[0], dat[0]});
    end
    reset_n = 1'b1;
    repeat (200) @(posedge clk); #1;
    checks++; if (rise_cnt[0] - r0 !== 0) begin errors++; $display("FAIL midframe_no_valid: got %0d expected 0", rise_cnt[0] - r0); end
    rdy[0] = 1'b1;
    send_frame(0, f8n1(8'h5A), 10, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (acc_dat[0] !== 9'h05A) begin errors++; $display("FAIL post_reset_data: got %h expected 05a", acc_dat[0]); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_two_stop();
    test_break();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fe.md
Name: uart_rx_fe

Overview:
- Parametrised successor UART receiver: configurable data width, parity mode and stop-bit count.
- 3-sample majority voting at mid-bit; false-start rejection.
- Detects parity error, framing error and line break.
- One-entry output holding register with valid/ready handshake and overrun reporting. Feeds command/byte parsers in the DDR2 controller debug path.

Parameters:
- BAUD_CNT_MAX, 5207, clk cycles per bit; legal range 8..16383.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx  in  1  asynchronous serial line, idle high
- ready  in  1  consumer accepts the held frame when valid&&ready
- data  out  DATA_BITS  received word, LSB first on the line
- valid  out  1  held frame available; stays high until accepted
- parity_err  out  1  parity mismatch for the held frame (0 when PARITY=0)
- frame_err  out  1  any checked stop bit sampled 0 for the held frame
- break_det  out  1  held frame is a line break
- overrun  out  1  one-cycle pulse: completed frame dropped because holder was full

Behaviour:
- Reset: sampled on the rising clk edge while reset_n=0.
  - All outputs 0.
  - Sync chain set to 1.
  - FSM to IDLE; counters 0.
  - Reset mid-frame abandons the frame and delivers nothing.
- Synchroniser: 2 flops plus 1 edge flop.
  - Start edge = previous synced 1, current synced 0, detected only in IDLE.
- Baud counter width is clog2(BAUD_CNT_MAX).
  - Loads 0 on start edge.
  - Counts 0..BAUD_CNT_MAX-1 and wraps while FSM is not IDLE.
- Sampling: H = BAUD_CNT_MAX/2. Samples are taken at counts H-1, H, H+1.
  - Bit value = majority of the 3 samples, decided at count H+1 (the decision strobe).
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE -> START on start edge.
  - START: majority 1 -> IDLE (false start, no output). Majority 0 -> DATA.
  - DATA: shift bit into data MSB, right-shift toward LSB. After DATA_BITS strobes -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare received bit with the computed bit. Odd: XOR of data bits and parity bit must be 1. Even: it must be 0. Then -> STOP.
  - STOP: one strobe per stop bit. Any 0 sets the frame error. After the last stop strobe the frame completes.
    - Break (all data bits 0, parity bit 0 if present, first stop bit 0) -> BRK_WAIT.
    - Otherwise -> IDLE in the same cycle, allowing a new start edge inside the last half stop bit.
  - BRK_WAIT: stay until synced rx=1, then -> IDLE. No start edge is accepted in this state.
- Completion: holder loads one cycle after the last stop strobe.
  - Fields loaded: data, parity_err, frame_err, break_det.
  - A break frame loads data=0, frame_err=1, break_det=1, parity_err=0.
- Handshake: valid rises on load and falls the cycle after valid&&ready. Output fields stay stable while valid=1.
- Simultaneous accept and completion: the new frame loads, valid stays 1, no overrun.
- Completion while valid=1 and ready=0: the new frame is discarded, held contents are unchanged, overrun pulses for 1 cycle.
- The receiver keeps running while valid=1; backpressure never stalls line sampling.

Decomposition:
- Shared uart package/include holds:
  - PARITY_NONE/ODD/EVEN constants.
  - FSM state encodings.
  - clog2 function.
- Natural sub-module: uart_bit_sampler.
  - Contains the synchroniser, edge detect, baud counter and majority vote.
  - Outputs start_edge, bit_strobe and bit_val.
  - Top level keeps the FSM, shift register, checks and holder.

Test Plan (BAUD_CNT_MAX=16 for speed):
- 8N1, send 0xA5, ready=1 -> one valid pulse, data=0xA5, all error flags 0, valid exactly 1 cycle after the stop-bit strobe.
- DATA_BITS=7, PARITY=2, send 0x03 with parity bit 1 -> data=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- rx low for 4 clocks, then high -> no valid, FSM back in IDLE. A following 0x3C frame is received correctly.
- STOP_BITS=2, send 0x55 with second stop bit 0 -> data=0x55, frame_err=1, break_det=0.
- Break:
  - Hold rx low for 30 bit times -> exactly one valid with data=0, frame_err=1, break_det=1.
  - No further frames while rx stays low.
  - After rx returns high, 0x81 is received correctly.
- Overrun and reset:
  - ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses 1 cycle at 0x22 completion. ready=1 accepts 0x11 and valid drops.
  - Separately, reset_n=0 mid-frame for 1 cycle -> all outputs 0 and no valid for the interrupted frame.
